// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of the parity-protected FIFO.
// Grants one valid producer per cycle, drops bad-parity words and counts them.
module fifo_push_arbiter #(
   parameter int         N_REQ      = 4,
   parameter int         DATA_WIDTH = 17,
   parameter logic       PARITY     = 1'b1,
   parameter int         CNT_WIDTH  = 16,
   localparam int        IDW        = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_grant,
   output logic                        valid_out,
   output logic [DATA_WIDTH-1:0]       data_out,
   output logic [IDW-1:0]              src_id,
   input  logic                        grant_in,
   output logic [CNT_WIDTH-1:0]        drop_cnt
);

   logic                  out_full_q, out_full_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IDW-1:0]        src_q, src_d;
   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CNT_WIDTH-1:0]  drop_q, drop_d;

   logic                  can_acc;
   logic                  found;
   logic [IDW-1:0]        sel;
   logic [IDW-1:0]        idx;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] word;
   logic                  parity_ok;

   // rst_n gates the grant so nothing is offered to producers while in reset
   assign can_acc = !out_full_q || grant_in;
   assign xfer    = found && can_acc && rst_n;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDW'((int'(rr_ptr_q) + k) % N_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      req_grant = '0;
      if (xfer) req_grant[sel] = 1'b1;
   end

   assign word      = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign parity_ok = ((^word) == ~PARITY);

   always_comb begin
      out_full_d = out_full_q;
      data_d     = data_q;
      src_d      = src_q;
      rr_ptr_d   = rr_ptr_q;
      drop_d     = drop_q;
      if (out_full_q && grant_in) out_full_d = 1'b0;
      if (xfer) begin
         rr_ptr_d = sel;
         if (parity_ok) begin
            out_full_d = 1'b1;
            data_d     = word;
            src_d      = sel;
         end else if (drop_q != '1) begin
            drop_d = drop_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_full_q <= 1'b0;
         data_q     <= '0;
         src_q      <= '0;
         rr_ptr_q   <= IDW'(N_REQ - 1);
         drop_q     <= '0;
      end else begin
         out_full_q <= out_full_d;
         data_q     <= data_d;
         src_q      <= src_d;
         rr_ptr_q   <= rr_ptr_d;
         drop_q     <= drop_d;
      end
   end

   assign valid_out = out_full_q;
   assign data_out  = data_q;
   assign src_id    = src_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed vector table, corner sequences,
// and random traffic against a queue-free behavioural model.
module tb_fifo_push_arbiter;

   localparam int N  = 4;
   localparam int DW = 17;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_grant;
   logic            valid_out;
   logic [DW-1:0]   data_out;
   logic [1:0]      src_id;
   logic            grant_in = 1'b0;
   logic [15:0]     drop_cnt;

   logic [N-1:0]    s_valid = '0;
   logic [N*DW-1:0] s_data = '0;
   logic [N-1:0]    s_grant;
   logic            s_vo;
   logic [DW-1:0]   s_do;
   logic [1:0]      s_src;
   logic            s_gin = 1'b1;
   logic [1:0]      s_drop;

   always #5 clk = ~clk;

   fifo_push_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .PARITY(1'b1), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_grant(req_grant), .valid_out(valid_out), .data_out(data_out),
      .src_id(src_id), .grant_in(grant_in), .drop_cnt(drop_cnt));

   fifo_push_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .PARITY(1'b1), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_data(s_data),
      .req_grant(s_grant), .valid_out(s_vo), .data_out(s_do),
      .src_id(s_src), .grant_in(s_gin), .drop_cnt(s_drop));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: last winner, one-word output buffer, drop tally
   int            m_last;
   bit            m_full;
   logic [DW-1:0] m_data;
   int            m_src;
   int            m_drop;

   function automatic void model_reset();
      m_last = N - 1; m_full = 0; m_data = '0; m_src = 0; m_drop = 0;
   endfunction

   function automatic logic [DW-1:0] mkw(input logic [15:0] p, input bit good);
      logic [DW-1:0] w;
      w = {1'b0, p};
      if ((^w) != 1'b0) w[DW-1] = 1'b1;
      if (!good) w[DW-1] = ~w[DW-1];
      return w;
   endfunction

   task automatic step(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] w,
                       input logic gin, output logic [N-1:0] gseen);
      int win;
      logic [N-1:0] eg;
      req_valid = v;
      req_data  = w;
      grant_in  = gin;
      @(negedge clk);
      win = -1;
      eg  = '0;
      if (!m_full || gin)
         for (int k = 1; k <= N; k++)
            if (win < 0 && v[(m_last + k) % N]) win = (m_last + k) % N;
      if (win >= 0) eg[win] = 1'b1;
      chk("model_grant", 32'(req_grant), 32'(eg));
      gseen = req_grant;
      @(posedge clk);
      if (m_full && gin) m_full = 0;
      if (win >= 0) begin
         m_last = win;
         if ((^w[win]) == 1'b0) begin
            m_full = 1; m_data = w[win]; m_src = win;
         end else if (m_drop < 65535) m_drop++;
      end
      #1;
      chk("model_valid", 32'(valid_out), 32'(m_full));
      chk("model_data", 32'(data_out), 32'(m_data));
      chk("model_src", 32'(src_id), 32'(m_src));
      chk("model_drop", 32'(drop_cnt), 32'(m_drop));
   endtask

   typedef struct {
      logic [N-1:0]          vld;
      logic [N-1:0][DW-1:0]  w;
      logic                  gin;
      logic [N-1:0]          gnt;
      logic                  vo;
      logic [DW-1:0]         dout;
      logic [1:0]            src;
      logic [15:0]           drop;
   } vec_t;

   function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] w,
                               input logic gin, input logic [N-1:0] g, input logic vo,
                               input logic [DW-1:0] d, input logic [1:0] s, input logic [15:0] dr);
      vec_t r;
      r.vld = v; r.w = w; r.gin = gin; r.gnt = g; r.vo = vo; r.dout = d; r.src = s; r.drop = dr;
      return r;
   endfunction

   localparam logic [DW-1:0] A0 = 17'h00011, A1 = 17'h00022, A2 = 17'h00044, A3 = 17'h00088;

   initial begin
      vec_t tbl[$];
      logic [N-1:0][DW-1:0] al;
      logic [N-1:0][DW-1:0] aw;
      logic [N-1:0] g;
      logic [DW-1:0] a [N];
      a[0] = A0; a[1] = A1; a[2] = A2; a[3] = A3;
      al = {A3, A2, A1, A0};

      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(4'hF, al, 1'b1, 4'(1 << (k % 4)), 1'b1, a[k % 4], 2'(k % 4), 16'd0));
      tbl.push_back(mk(4'b0100, {17'h0, 17'h00003, 17'h0, 17'h0}, 1'b1, 4'b0100, 1'b1, 17'h00003, 2'd2, 16'd0));
      tbl.push_back(mk(4'b0010, {17'h0, 17'h0, 17'h00001, 17'h0}, 1'b1, 4'b0010, 1'b0, 17'h00003, 2'd2, 16'd1));
      tbl.push_back(mk(4'b0010, {17'h0, 17'h0, 17'h00003, 17'h0}, 1'b1, 4'b0010, 1'b1, 17'h00003, 2'd1, 16'd1));
      tbl.push_back(mk(4'b0011, al, 1'b1, 4'b0001, 1'b1, A0, 2'd0, 16'd1));
      tbl.push_back(mk(4'b0011, al, 1'b1, 4'b0010, 1'b1, A1, 2'd1, 16'd1));
      tbl.push_back(mk(4'b0000, al, 1'b1, 4'b0000, 1'b0, A1, 2'd1, 16'd1));

      model_reset();
      rst_n = 1'b0;
      req_valid = 4'hF;
      #13;
      chk("reset_grant", 32'(req_grant), 32'd0);
      chk("reset_valid", 32'(valid_out), 32'd0);
      chk("reset_data", 32'(data_out), 32'd0);
      chk("reset_src", 32'(src_id), 32'd0);
      chk("reset_drop", 32'(drop_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].vld, tbl[i].w, tbl[i].gin, g);
         chk($sformatf("vec%0d_grant", i), 32'(g), 32'(tbl[i].gnt));
         chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(tbl[i].vo));
         chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(tbl[i].dout));
         chk($sformatf("vec%0d_src", i), 32'(src_id), 32'(tbl[i].src));
         chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
      end

      // Backpressure: fill, stall five cycles, then pop and reload together
      step(4'hF, al, 1'b0, g);
      chk("bp_fill_grant", 32'(g), 32'b0100);
      chk("bp_fill_data", 32'(data_out), 32'(A2));
      for (int k = 0; k < 5; k++) begin
         step(4'hF, al, 1'b0, g);
         chk("bp_stall_grant", 32'(g), 32'd0);
         chk("bp_stall_data", 32'(data_out), 32'(A2));
         chk("bp_stall_valid", 32'(valid_out), 32'd1);
      end
      step(4'hF, al, 1'b1, g);
      chk("bp_release_grant", 32'(g), 32'b1000);
      chk("bp_release_valid", 32'(valid_out), 32'd1);
      chk("bp_release_data", 32'(data_out), 32'(A3));

      // Reset between edges while holding a stalled word
      step(4'hF, al, 1'b0, g);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(valid_out), 32'd0);
      chk("midrst_drop", 32'(drop_cnt), 32'd0);
      chk("midrst_data", 32'(data_out), 32'd0);
      chk("midrst_grant", 32'(req_grant), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      step(4'hF, al, 1'b1, g);
      chk("midrst_first_grant", 32'(g), 32'b0001);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            aw[i] = mkw(16'($urandom), $urandom_range(0, 4) != 0);
         step(4'($urandom), aw, $urandom_range(0, 9) < 7, g);
      end

      // Drop counter saturation on the narrow-counter instance
      s_gin   = 1'b1;
      s_valid = 4'b0001;
      s_data  = {51'h0, 17'h00001};
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("sat_grant", 32'(s_grant), 32'b0001);
         @(posedge clk); #1;
         chk("sat_drop", 32'(s_drop), (k < 3) ? 32'(k) : 32'd3);
         chk("sat_valid", 32'(s_vo), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
